// File: rtl/riscv_dtm_dmi_if.sv
`default_nettype none
// ============================================================================
// riscv_dtm_dmi_if : DMI request/response bus between a DTM and a Debug Module
// Rev 1.0
// ============================================================================
interface riscv_dtm_dmi_if #(
  parameter int ABITS = 7
) ();
  logic             dmi_req_valid_o;
  logic             dmi_req_ready_i;
  logic [ABITS-1:0] dmi_req_addr_o;
  logic [31:0]      dmi_req_data_o;
  logic [1:0]       dmi_req_op_o;
  logic             dmi_rsp_valid_i;
  logic             dmi_rsp_ready_o;
  logic [31:0]      dmi_rsp_data_i;
  logic [1:0]       dmi_rsp_op_i;

  modport master (
    output dmi_req_valid_o, dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o, dmi_rsp_ready_o,
    input  dmi_req_ready_i, dmi_rsp_valid_i, dmi_rsp_data_i, dmi_rsp_op_i
  );

  modport slave (
    input  dmi_req_valid_o, dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o, dmi_rsp_ready_o,
    output dmi_req_ready_i, dmi_rsp_valid_i, dmi_rsp_data_i, dmi_rsp_op_i
  );
endinterface
`default_nettype wire

// File: rtl/riscv_dtm_dmi.sv
`default_nettype none
// ============================================================================
// riscv_dtm_dmi : JTAG DTM driving a DMI req/rsp handshake with sticky status.
// Optional macro RISCV_DTM_TIMEOUT_EN adds a response timeout.   Rev 1.0
// ============================================================================
module riscv_dtm_dmi #(
  parameter logic [31:0] IDCODE      = 32'h1DEAD3FF,
  parameter int          ABITS       = 7,
  parameter int          IDLE_CYCLES = 1,
  parameter int          IR_LEN      = 5,
  parameter int          TIMEOUT     = 255
) (
  input  logic              tck_i,
  input  logic              rst_i,
  input  logic              tdi_i,
  output logic              tdo_o,
  input  logic              capture_dr_i,
  input  logic              shift_dr_i,
  input  logic              update_dr_i,
  input  logic [IR_LEN-1:0] ir_i,
  riscv_dtm_dmi_if.master   dmi
);

  localparam int                DMI_W     = ABITS + 34;
  localparam logic [IR_LEN-1:0] IR_IDCODE = IR_LEN'(1);
  localparam logic [IR_LEN-1:0] IR_DTMCS  = IR_LEN'(16);
  localparam logic [IR_LEN-1:0] IR_DMI    = IR_LEN'(17);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       sticky;
  logic [1:0]       sticky_set;
  logic [ABITS-1:0] last_addr;
  logic [ABITS-1:0] req_addr;
  logic [31:0]      req_data;
  logic [1:0]       req_op;
  logic [31:0]      rsp_data;
  logic             req_valid;
  logic             rsp_ready;
  logic [31:0]      idcode_sr;
  logic [31:0]      dtmcs_sr;
  logic [DMI_W-1:0] dmi_sr;
  logic             bypass_sr;

  logic             sel_idcode;
  logic             sel_dtmcs;
  logic             sel_dmi;
  logic             hardreset;
  logic             dmireset;
  logic             load_req;
  logic             rsp_take;
  logic             timeout_hit;
  logic [1:0]       dmi_status;
  logic [ABITS-1:0] upd_addr;
  logic [31:0]      upd_data;
  logic [1:0]       upd_op;

  assign sel_idcode = (ir_i == IR_IDCODE);
  assign sel_dtmcs  = (ir_i == IR_DTMCS);
  assign sel_dmi    = (ir_i == IR_DMI);

  assign hardreset  = update_dr_i && sel_dtmcs && dtmcs_sr[17];
  assign dmireset   = update_dr_i && sel_dtmcs && dtmcs_sr[16];

  assign upd_addr   = dmi_sr[DMI_W-1:34];
  assign upd_data   = dmi_sr[33:2];
  assign upd_op     = dmi_sr[1:0];

  // Sticky error dominates; otherwise an access still in flight reads as busy.
  assign dmi_status = (sticky != 2'd0) ? sticky : ((state != IDLE) ? 2'd3 : 2'd0);

  // A response landing on the hardreset edge is discarded.
  assign rsp_take   = (state == RSP) && dmi.dmi_rsp_valid_i && !hardreset;

`ifdef RISCV_DTM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 255) ? 16 : 8;
  logic [CNT_W-1:0] tmo_cnt;

  always_ff @(posedge tck_i) begin
    if (rst_i || (state_nxt != state)) begin
      tmo_cnt <= '0;
    end else if (state != IDLE) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  assign timeout_hit = (state != IDLE) && (tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    sticky_set = 2'd0;
    load_req   = 1'b0;
    case (state)
      REQ: begin
        if (dmi.dmi_req_ready_i) state_nxt = RSP;
      end
      RSP: begin
        if (dmi.dmi_rsp_valid_i) begin
          state_nxt = IDLE;
          if (dmi.dmi_rsp_op_i == 2'd2)      sticky_set = 2'd2;
          else if (dmi.dmi_rsp_op_i != 2'd0) sticky_set = 2'd3;
        end
      end
      default: ;
    endcase
    if (timeout_hit && !((state == RSP) && dmi.dmi_rsp_valid_i)) begin
      state_nxt  = IDLE;
      sticky_set = 2'd2;
    end
    if (capture_dr_i && sel_dmi && (state != IDLE) && (sticky_set == 2'd0)) begin
      sticky_set = 2'd3;
    end
    if (update_dr_i && sel_dmi && (sticky == 2'd0)) begin
      if (state != IDLE) begin
        if (sticky_set == 2'd0) sticky_set = 2'd3;
      end else if ((upd_op == 2'd1) || (upd_op == 2'd2)) begin
        load_req  = 1'b1;
        state_nxt = REQ;
      end
    end
    if (hardreset) begin
      state_nxt = IDLE;
      load_req  = 1'b0;
    end
  end

  // Handshake outputs are registered copies of the next state: no combinational valid path.
  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      state     <= IDLE;
      req_valid <= 1'b0;
      rsp_ready <= 1'b0;
      req_addr  <= '0;
      req_data  <= '0;
      req_op    <= '0;
      last_addr <= '0;
      rsp_data  <= '0;
    end else begin
      state     <= state_nxt;
      req_valid <= (state_nxt == REQ);
      rsp_ready <= (state_nxt != REQ);
      if (load_req) begin
        req_addr  <= upd_addr;
        req_data  <= upd_data;
        req_op    <= upd_op;
        last_addr <= upd_addr;
      end
      if (rsp_take && (dmi.dmi_rsp_op_i == 2'd0) && (req_op == 2'd1)) begin
        rsp_data <= dmi.dmi_rsp_data_i;
      end
    end
  end

  // First error wins; clears take precedence over any same-edge error.
  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      sticky <= 2'd0;
    end else if (hardreset || dmireset) begin
      sticky <= 2'd0;
    end else if (sticky == 2'd0) begin
      sticky <= sticky_set;
    end
  end

  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      idcode_sr <= IDCODE;
      dtmcs_sr  <= '0;
      dmi_sr    <= '0;
      bypass_sr <= 1'b0;
    end else if (capture_dr_i) begin
      if (sel_idcode)     idcode_sr <= IDCODE;
      else if (sel_dtmcs) dtmcs_sr  <= {14'b0, 2'b0, 1'b0, 3'(IDLE_CYCLES), sticky, 6'(ABITS), 4'd1};
      else if (sel_dmi)   dmi_sr    <= {last_addr, rsp_data, dmi_status};
      else                bypass_sr <= 1'b0;
    end else if (shift_dr_i) begin
      if (sel_idcode)     idcode_sr <= {tdi_i, idcode_sr[31:1]};
      else if (sel_dtmcs) dtmcs_sr  <= {tdi_i, dtmcs_sr[31:1]};
      else if (sel_dmi)   dmi_sr    <= {tdi_i, dmi_sr[DMI_W-1:1]};
      else                bypass_sr <= tdi_i;
    end
  end

  always_comb begin
    tdo_o = bypass_sr;
    if (sel_idcode)     tdo_o = idcode_sr[0];
    else if (sel_dtmcs) tdo_o = dtmcs_sr[0];
    else if (sel_dmi)   tdo_o = dmi_sr[0];
  end

  assign dmi.dmi_req_valid_o = req_valid;
  assign dmi.dmi_req_addr_o  = req_addr;
  assign dmi.dmi_req_data_o  = req_data;
  assign dmi.dmi_req_op_o    = req_op;
  assign dmi.dmi_rsp_ready_o = rsp_ready;

endmodule
`default_nettype wire

// File: tb/tb_riscv_dtm_dmi.sv
`default_nettype none
// Directed bench for riscv_dtm_dmi: JTAG scans against a scripted Debug Module.
module tb_riscv_dtm_dmi;

  localparam int          ABITS     = 7;
  localparam int          IR_LEN    = 5;
  localparam int          DMI_W     = ABITS + 34;
  localparam logic [IR_LEN-1:0] IR_IDCODE = 5'h01;
  localparam logic [IR_LEN-1:0] IR_DTMCS  = 5'h10;
  localparam logic [IR_LEN-1:0] IR_DMI    = 5'h11;
  localparam logic [IR_LEN-1:0] IR_BYP    = 5'h1F;
`ifdef RISCV_DTM_TIMEOUT_EN
  localparam logic [1:0]  HANG_STAT = 2'd2;
  localparam logic        HANG_RSP_STATE = 1'b0;
`else
  localparam logic [1:0]  HANG_STAT = 2'd3;
  localparam logic        HANG_RSP_STATE = 1'b1;
`endif

  logic              tck = 1'b0;
  logic              rst;
  logic              tdi;
  logic              tdo;
  logic              capture_dr;
  logic              shift_dr;
  logic              update_dr;
  logic [IR_LEN-1:0] ir;

  riscv_dtm_dmi_if #(.ABITS(ABITS)) dmi ();

  riscv_dtm_dmi #(
    .ABITS (ABITS),
    .IR_LEN(IR_LEN)
  ) dut (
    .tck_i       (tck),
    .rst_i       (rst),
    .tdi_i       (tdi),
    .tdo_o       (tdo),
    .capture_dr_i(capture_dr),
    .shift_dr_i  (shift_dr),
    .update_dr_i (update_dr),
    .ir_i        (ir),
    .dmi         (dmi)
  );

  always #5 tck = ~tck;

  int vectors     = 0;
  int miscompares = 0;

  // Scripted Debug Module controls and request log
  logic        dm_ready_en  = 1'b1;
  logic        dm_rsp_en    = 1'b1;
  logic [1:0]  dm_rsp_op    = 2'd0;
  logic [31:0] dm_rsp_data  = 32'h0;
  int          beats        = 0;
  logic [6:0]  beat_addr    = '0;
  logic [31:0] beat_data    = '0;
  logic [1:0]  beat_op      = '0;

  initial begin : dm_model
    logic        hs_req, hs_rsp, pend;
    logic [6:0]  a;
    logic [31:0] d;
    logic [1:0]  o;
    pend = 1'b0;
    dmi.dmi_req_ready_i = 1'b0;
    dmi.dmi_rsp_valid_i = 1'b0;
    dmi.dmi_rsp_data_i  = '0;
    dmi.dmi_rsp_op_i    = '0;
    forever begin
      @(negedge tck);
      hs_req = dmi.dmi_req_valid_o && dmi.dmi_req_ready_i;
      hs_rsp = dmi.dmi_rsp_valid_i && dmi.dmi_rsp_ready_o;
      a = dmi.dmi_req_addr_o;
      d = dmi.dmi_req_data_o;
      o = dmi.dmi_req_op_o;
      @(posedge tck);
      #1;
      if (hs_req) begin
        beats++;
        beat_addr = a;
        beat_data = d;
        beat_op   = o;
        pend      = 1'b1;
      end
      if (hs_rsp) dmi.dmi_rsp_valid_i = 1'b0;
      if (pend && dm_rsp_en && !dmi.dmi_rsp_valid_i) begin
        dmi.dmi_rsp_valid_i = 1'b1;
        dmi.dmi_rsp_data_i  = dm_rsp_data;
        dmi.dmi_rsp_op_i    = dm_rsp_op;
        pend = 1'b0;
      end
      dmi.dmi_req_ready_i = dm_ready_en;
    end
  end

  function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d,
                                           input logic [1:0] op);
    return {23'b0, a, d, op};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge tck);
  endtask

  // Capture, shift len bits LSB-first (sampling tdo), then update.
  task automatic scan_dr(input logic [IR_LEN-1:0] ir_v, input logic [63:0] din, input int len,
                         output logic [63:0] dout);
    dout = '0;
    @(negedge tck);
    ir = ir_v;
    capture_dr = 1'b1;
    @(negedge tck);
    capture_dr = 1'b0;
    shift_dr   = 1'b1;
    for (int i = 0; i < len; i++) begin
      tdi     = din[i];
      dout[i] = tdo;
      @(negedge tck);
    end
    shift_dr  = 1'b0;
    update_dr = 1'b1;
    @(negedge tck);
    update_dr = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; tdi = 1'b0; capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
    ir  = IR_IDCODE;
    repeat (2) @(negedge tck);
    vectors++;
    if (dmi.dmi_req_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_req_valid: got %b expected 0", dmi.dmi_req_valid_o);
    end
    vectors++;
    if (dmi.dmi_rsp_ready_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_rsp_ready: got %b expected 0", dmi.dmi_rsp_ready_o);
    end
    vectors++;
    if (tdo !== 1'b1) begin
      miscompares++; $display("FAIL reset_tdo_idcode_bit0: got %b expected 1", tdo);
    end
    rst = 1'b0;
    @(negedge tck);
    vectors++;
    if (dmi.dmi_rsp_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL idle_rsp_ready: got %b expected 1", dmi.dmi_rsp_ready_o);
    end
  endtask

  task automatic test_idcode_dtmcs;
    logic [63:0] d;
    scan_dr(IR_IDCODE, 64'h0, 32, d);
    vectors++;
    if (d !== 64'h1DEAD3FF) begin
      miscompares++; $display("FAIL idcode_scan: got %h expected 1dead3ff", d);
    end
    scan_dr(IR_DTMCS, 64'h0, 32, d);
    vectors++;
    if (d !== 64'h00001071) begin
      miscompares++; $display("FAIL dtmcs_scan: got %h expected 00001071", d);
    end
  endtask

  task automatic test_bypass;
    logic [63:0] d;
    scan_dr(IR_BYP, 64'hA5, 8, d);
    vectors++;
    if (d !== 64'h4A) begin
      miscompares++; $display("FAIL bypass_ones: got %h expected 4a", d);
    end
    scan_dr(5'h05, 64'hA5, 8, d);
    vectors++;
    if (d !== 64'h4A) begin
      miscompares++; $display("FAIL bypass_unknown_ir: got %h expected 4a", d);
    end
  endtask

  task automatic test_dmi_write;
    logic [63:0] d;
    int b0;
    b0 = beats;
    dm_rsp_op = 2'd0; dm_rsp_data = 32'hFFFF_FFFF;
    scan_dr(IR_DMI, dmi_word(7'h10, 32'hA5A5_0001, 2'd2), DMI_W, d);
    idle(6);
    vectors++;
    if (beats !== b0 + 1) begin
      miscompares++; $display("FAIL write_beats: got %0d expected %0d", beats, b0 + 1);
    end
    vectors++;
    if ({beat_addr, beat_data, beat_op} !== {7'h10, 32'hA5A5_0001, 2'd2}) begin
      miscompares++;
      $display("FAIL write_req_fields: got %h/%h/%h expected 10/a5a50001/2", beat_addr, beat_data, beat_op);
    end
    scan_dr(IR_DMI, dmi_word(7'h0, 32'h0, 2'd0), DMI_W, d);
    vectors++;
    if (d !== dmi_word(7'h10, 32'h0, 2'd0)) begin
      miscompares++; $display("FAIL write_capture: got %h expected %h", d, dmi_word(7'h10, 32'h0, 2'd0));
    end
  endtask

  task automatic test_dmi_read;
    logic [63:0] d;
    dm_rsp_data = 32'h0030_0382;
    scan_dr(IR_DMI, dmi_word(7'h11, 32'h0, 2'd1), DMI_W, d);
    idle(6);
    vectors++;
    if (beat_op !== 2'd1 || beat_addr !== 7'h11) begin
      miscompares++; $display("FAIL read_req_fields: got %h/%h expected 11/1", beat_addr, beat_op);
    end
    scan_dr(IR_DMI, dmi_word(7'h0, 32'h0, 2'd0), DMI_W, d);
    vectors++;
    if (d !== dmi_word(7'h11, 32'h0030_0382, 2'd0)) begin
      miscompares++; $display("FAIL read_capture: got %h expected %h", d, dmi_word(7'h11, 32'h0030_0382, 2'd0));
    end
  endtask

  task automatic test_busy;
    logic [63:0] d;
    int b0;
    b0 = beats;
    dm_ready_en = 1'b0;
    scan_dr(IR_DMI, dmi_word(7'h12, 32'h0, 2'd1), DMI_W, d);
    idle(2);
    vectors++;
    if (dmi.dmi_req_valid_o !== 1'b1) begin
      miscompares++; $display("FAIL busy_req_valid: got %b expected 1", dmi.dmi_req_valid_o);
    end
    scan_dr(IR_DMI, dmi_word(7'h0, 32'h0, 2'd0), DMI_W, d);
    vectors++;
    if (d !== dmi_word(7'h12, 32'h0030_0382, 2'd3)) begin
      miscompares++; $display("FAIL busy_capture: got %h expected %h", d, dmi_word(7'h12, 32'h0030_0382, 2'd3));
    end
    idle(20);
    vectors++;
    if (dmi.dmi_req_valid_o !== 1'b1 || dmi.dmi_req_addr_o !== 7'h12) begin
      miscompares++;
      $display("FAIL busy_req_held: got %b/%h expected 1/12", dmi.dmi_req_valid_o, dmi.dmi_req_addr_o);
    end
    dm_rsp_data = 32'hDEAD_0012;
    dm_ready_en = 1'b1;
    idle(6);
    scan_dr(IR_DMI, dmi_word(7'h13, 32'h0, 2'd1), DMI_W, d);
    idle(6);
    vectors++;
    if (beats !== b0 + 1 || dmi.dmi_req_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL sticky_blocks_req: got beats %0d valid %b expected %0d 0",
                              beats, dmi.dmi_req_valid_o, b0 + 1);
    end
    scan_dr(IR_DTMCS, 64'h1_0000, 32, d);
    vectors++;
    if (d !== 64'h00001C71) begin
      miscompares++; $display("FAIL dmistat_busy: got %h expected 00001c71", d);
    end
    scan_dr(IR_DTMCS, 64'h0, 32, d);
    vectors++;
    if (d !== 64'h00001071) begin
      miscompares++; $display("FAIL dmireset_clears: got %h expected 00001071", d);
    end
    dm_rsp_data = 32'h1234_5678;
    scan_dr(IR_DMI, dmi_word(7'h14, 32'h0, 2'd1), DMI_W, d);
    idle(6);
    scan_dr(IR_DMI, dmi_word(7'h0, 32'h0, 2'd0), DMI_W, d);
    vectors++;
    if (d !== dmi_word(7'h14, 32'h1234_5678, 2'd0)) begin
      miscompares++; $display("FAIL read_after_reset: got %h expected %h", d, dmi_word(7'h14, 32'h1234_5678, 2'd0));
    end
  endtask

  task automatic test_failed;
    logic [63:0] d;
    dm_rsp_op = 2'd2;
    scan_dr(IR_DMI, dmi_word(7'h15, 32'h0, 2'd1), DMI_W, d);
    idle(6);
    scan_dr(IR_DTMCS, 64'h1_0000, 32, d);
    vectors++;
    if (d !== 64'h00001871) begin
      miscompares++; $display("FAIL dmistat_failed: got %h expected 00001871", d);
    end
    dm_rsp_op = 2'd0;
    scan_dr(IR_DTMCS, 64'h0, 32, d);
    vectors++;
    if (d !== 64'h00001071) begin
      miscompares++; $display("FAIL failed_cleared: got %h expected 00001071", d);
    end
  endtask

  task automatic test_hardreset;
    logic [63:0] d;
    int b0;
    b0 = beats;
    dm_ready_en = 1'b0;
    scan_dr(IR_DMI, dmi_word(7'h16, 32'h0, 2'd1), DMI_W, d);
    idle(2);
    vectors++;
    if (dmi.dmi_req_valid_o !== 1'b1) begin
      miscompares++; $display("FAIL hr_pending: got %b expected 1", dmi.dmi_req_valid_o);
    end
    scan_dr(IR_DTMCS, 64'h2_0000, 32, d);
    vectors++;
    if (dmi.dmi_req_valid_o !== 1'b0 || dmi.dmi_rsp_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL hr_drop_valid: got %b/%b expected 0/1",
                              dmi.dmi_req_valid_o, dmi.dmi_rsp_ready_o);
    end
    dm_ready_en = 1'b1;
    idle(4);
    vectors++;
    if (beats !== b0) begin
      miscompares++; $display("FAIL hr_no_beat: got %0d expected %0d", beats, b0);
    end
    scan_dr(IR_DMI, dmi_word(7'h0, 32'h0, 2'd0), DMI_W, d);
    vectors++;
    if (d !== dmi_word(7'h16, 32'h1234_5678, 2'd0)) begin
      miscompares++; $display("FAIL hr_idle_capture: got %h expected %h", d, dmi_word(7'h16, 32'h1234_5678, 2'd0));
    end
  endtask

  task automatic test_no_response;
    logic [63:0] d;
    dm_rsp_en = 1'b0;
    scan_dr(IR_DMI, dmi_word(7'h17, 32'h0, 2'd1), DMI_W, d);
    idle(1000);
    vectors++;
    if (dmi.dmi_req_valid_o !== 1'b0 || dmi.dmi_rsp_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL hang_outputs: got %b/%b expected 0/1",
                              dmi.dmi_req_valid_o, dmi.dmi_rsp_ready_o);
    end
    scan_dr(IR_DMI, dmi_word(7'h0, 32'h0, 2'd0), DMI_W, d);
    vectors++;
    if (d !== dmi_word(7'h17, 32'h1234_5678, HANG_STAT)) begin
      miscompares++; $display("FAIL hang_capture: got %h expected %h", d, dmi_word(7'h17, 32'h1234_5678, HANG_STAT));
    end
    scan_dr(IR_DTMCS, 64'h2_0000, 32, d);
    vectors++;
    if (d !== (64'h00001071 | (64'(HANG_STAT) << 10))) begin
      miscompares++; $display("FAIL hang_dmistat: got %h expected stat %0d", d, HANG_STAT);
    end
    dm_rsp_data = 32'hBAD0_BAD0;
    dm_rsp_en   = 1'b1;
    idle(6);
    scan_dr(IR_DMI, dmi_word(7'h0, 32'h0, 2'd0), DMI_W, d);
    vectors++;
    if (d !== dmi_word(7'h17, 32'h1234_5678, 2'd0)) begin
      miscompares++; $display("FAIL late_rsp_drained: got %h expected %h (rsp_state %b)",
                              d, dmi_word(7'h17, 32'h1234_5678, 2'd0), HANG_RSP_STATE);
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] d;
    int b0;
    b0 = beats;
    dm_ready_en = 1'b0;
    scan_dr(IR_DMI, dmi_word(7'h18, 32'h0, 2'd1), DMI_W, d);
    idle(2);
    rst = 1'b1;
    @(negedge tck);
    vectors++;
    if (dmi.dmi_req_valid_o !== 1'b0 || dmi.dmi_rsp_ready_o !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset_outputs: got %b/%b expected 0/0",
                              dmi.dmi_req_valid_o, dmi.dmi_rsp_ready_o);
    end
    rst = 1'b0;
    dm_ready_en = 1'b1;
    idle(4);
    vectors++;
    if (beats !== b0) begin
      miscompares++; $display("FAIL mid_reset_no_beat: got %0d expected %0d", beats, b0);
    end
    scan_dr(IR_DMI, dmi_word(7'h0, 32'h0, 2'd0), DMI_W, d);
    vectors++;
    if (d !== 64'h0) begin
      miscompares++; $display("FAIL mid_reset_capture: got %h expected 0", d);
    end
  endtask

  initial begin
    test_reset();
    test_idcode_dtmcs();
    test_bypass();
    test_dmi_write();
    test_dmi_read();
    test_busy();
    test_failed();
    test_hardreset();
    test_no_response();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_dtm_dmi.md
Name: riscv_dtm_dmi

Overview:
Second-generation JTAG Debug Transport Module. It sits between the TAP controller and a Debug Module, and is clocked on tck_i. Unlike the fixed-response minimal DTM, it drives a real DMI request/response handshake to the DM and tracks outstanding accesses. It reports sticky busy/failed status through dmistat and the DMI op field, and supports dmireset and dmihardreset. Address width, idle hint and IR length are parametrised.

Parameters:
IDCODE, 32'h1DEAD3FF, value loaded by IDCODE capture
ABITS, 7, DMI address width (legal 1..32); DMI DR length = ABITS+34
IDLE_CYCLES, 1, value reported in dtmcs.idle[14:12] (0..7)
IR_LEN, 5, instruction register width
TIMEOUT, 255, response timeout in tck_i cycles (used only with RISCV_DTM_TIMEOUT_EN)

Ports:
tck_i  in  1  JTAG clock; all state updates on the rising edge
rst_i  in  1  reset, synchronous to tck_i, active-high
tdi_i  in  1  serial data in
tdo_o  out  1  serial data out, combinational mux of selected DR bit 0
capture_dr_i  in  1  TAP in Capture-DR
shift_dr_i  in  1  TAP in Shift-DR
update_dr_i  in  1  TAP in Update-DR
ir_i  in  IR_LEN  current instruction
dmi_req_valid_o  out  1  DMI request valid
dmi_req_ready_i  in  1  DM accepts request
dmi_req_addr_o  out  ABITS  request address
dmi_req_data_o  out  32  request write data
dmi_req_op_o  out  2  1=read, 2=write
dmi_rsp_valid_i  in  1  DM response valid
dmi_rsp_ready_o  out  1  DTM accepts response
dmi_rsp_data_i  in  32  response read data
dmi_rsp_op_i  in  2  0=ok, 2=failed, 3=busy

Behaviour:
- Opcodes: IDCODE=0x01, DTMCS=0x10, DMI=0x11, BYPASS=all ones. Any other value selects the 1-bit bypass register. Opcodes are zero-extended to IR_LEN.
- Reset (rst_i=1 at an edge): state=IDLE, sticky=0, last_addr=0, rsp_data=0, all request outputs 0, dmi_rsp_ready_o=0, idcode shift=IDCODE, other shift registers 0. tdo_o follows the mux.
- Capture-DR (IDCODE/DTMCS/BYPASS): loads IDCODE / {14'b0,2'b0,1'b0,IDLE_CYCLES,sticky,ABITS[5:0],4'd1} / 0.
- Capture-DR (DMI): loads {last_addr, rsp_data, status}. status = sticky if sticky≠0; otherwise 3 if state≠IDLE, in which case sticky←3 at the same edge; otherwise 0.
- Capture uses the registered state from before that edge, so a response arriving on the same edge is not yet visible.
- Shift-DR: LSB-first right shift of the selected register, tdi_i into the MSB.
- Update-DR with DMI, fields addr=[ABITS+33:34], data=[33:2], op=[1:0]:
  - sticky≠0: ignored.
  - state≠IDLE: sticky←3, ignored.
  - op 1 or 2: latch addr/data/op, last_addr←addr, state←REQ; dmi_req_valid_o=1 from the next cycle.
  - op 0 or 3: no effect.
- Update-DR with DTMCS, data bit17 = dmihardreset: sticky←0, state←IDLE, dmi_req_valid_o←0. An in-flight response is then discarded (rsp_ready_o stays 1 in IDLE only for draining; data is ignored).
- Update-DR with DTMCS, data bit16 = dmireset: sticky←0 only. If bit17 is also set, hardreset takes precedence.
- FSM:
  - IDLE: dmi_rsp_ready_o=1 (drain only).
  - REQ: dmi_req_valid_o=1, outputs held stable until dmi_req_ready_i=1 at an edge, then →RSP.
  - RSP: dmi_rsp_ready_o=1. On dmi_rsp_valid_i: op 0 → rsp_data←dmi_rsp_data_i (reads only; writes leave rsp_data); op 2 → sticky←2; op 3 or 1 → sticky←3. Then →IDLE.
- Minimum latency from Update-DR to the request handshake is 1 cycle; there is no combinational valid path.
- rst_i mid-transaction: aborts immediately to the reset state; no further handshake is issued.
- Sticky status is only ever written to a nonzero value when its current value is 0; the first error wins.

Optional Feature:
RISCV_DTM_TIMEOUT_EN:
- Defined: an 8..16-bit counter clears on entry to REQ/RSP and increments each cycle in REQ or RSP. On reaching TIMEOUT it sets sticky←2, state←IDLE and deasserts dmi_req_valid_o. Any late response is drained and discarded in IDLE.
- Undefined: no counter is present; the FSM waits indefinitely, and dmihardreset is the only recovery.

Test Plan:
- Reset, IR=0x01, shift 32 bits → tdo sequence LSB-first = 0x1DEAD3FF; IR=0x10 → 0x00001071 (IDLE_CYCLES=1, ABITS=7, version 1).
- DMI write addr 0x10, data 0xA5A5_0001, op 2, ready_i held 1 → one req beat with addr=0x10, data=0xA5A50001, op=2. rsp op 0; next DMI scan captures status 0, addr 0x10.
- DMI read addr 0x11; DM returns 0x0030_0382 op 0 → next scan shifts out data 0x00300382, op 0.
- Read with ready_i low for 20 cycles and a rescan during the wait → captured op 3, sticky=3. Later scans are ignored and no new req is issued; dtmcs.dmistat=3. DTMCS write bit16 → dmistat=0 and the next read succeeds.
- DM returns op 2 → dmistat=2. DTMCS write with bit17 while a request is pending → req_valid drops the next cycle, state IDLE, dmistat=0.
- With RISCV_DTM_TIMEOUT_EN and TIMEOUT=16: read that never gets rsp_valid → req/rsp abandoned after 16 cycles, dmistat=2. Without the macro, the FSM is still in RSP after 1000 cycles.
